// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that hands one byte at a time to a UART transmitter,
// holds tx_start for a fixed window and waits for the tx_clk-domain tx_done.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | no frame in flight; requests are arbitrated here
// START     | tx_start held high for START_CYCLES
// WAIT_DONE | waiting for a synchronized rising edge of tx_done
// GAP       | idle spacing of GAP_CYCLES before the next arbitration
// ABORT     | one-cycle abort after a timeout; done pulsed, error latched
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int START_CYCLES   = 10417,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int GAP_CYCLES     = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              grant,
  output logic [N_REQ-1:0]              done,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         data_out,
  input  logic                          tx_done,
  output logic                          busy,
  output logic [$clog2(N_REQ)-1:0]      owner,
  output logic                          timeout_err
);

  localparam int OW        = $clog2(N_REQ);
  localparam int CNT_TOP   = (START_CYCLES > TIMEOUT_CYCLES) ? START_CYCLES : TIMEOUT_CYCLES;
  localparam int CW        = $clog2(CNT_TOP + 1);
  localparam int GW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CW-1:0] START_LAST = CW'(START_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT    = {CW{1'b1}};
  localparam logic [GW-1:0] GAP_LOAD   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_DONE = 3'd2,
    GAP       = 3'd3,
    ABORT     = 3'd4
  } state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt;
  logic [GW-1:0]   gap_cnt;
  logic            sync_q1, sync_q2, sync_q3;
  logic            completion;
  logic [OW-1:0]   pick;
  logic            grant_set, done_set, abort_set;

  // Scanning from the farthest slot down leaves the nearest set bit after last.
  function automatic logic [OW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [OW-1:0]    last);
    int idx;
    rr_pick = last;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (r[idx]) rr_pick = OW'(idx);
    end
  endfunction

  assign completion = sync_q2 & ~sync_q3;
  assign pick       = rr_pick(req, owner);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Completion takes priority over a timeout landing in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (|req) next_state = START;
      START: begin
        if (cnt >= TO_LAST)         next_state = ABORT;
        else if (cnt == START_LAST) next_state = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (completion)             next_state = (GAP_CYCLES == 0) ? IDLE : GAP;
        else if (cnt >= TO_LAST)    next_state = ABORT;
      end
      GAP:       if (gap_cnt == '0) next_state = IDLE;
      ABORT:     next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    tx_start  = (state == START);
    busy      = (state != IDLE);
    grant_set = (state == IDLE) && (next_state == START);
    abort_set = (state != ABORT) && (next_state == ABORT);
    done_set  = abort_set || ((state == WAIT_DONE) && completion);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant       <= '0;
      done        <= '0;
      data_out    <= '0;
      owner       <= OW'(N_REQ - 1);
      timeout_err <= 1'b0;
      cnt         <= '0;
      gap_cnt     <= '0;
      sync_q1     <= 1'b0;
      sync_q2     <= 1'b0;
      sync_q3     <= 1'b0;
    end else begin
      sync_q1 <= tx_done;
      sync_q2 <= sync_q1;
      sync_q3 <= sync_q2;
      grant   <= '0;
      done    <= '0;
      if (grant_set) begin
        grant[pick] <= 1'b1;
        owner       <= pick;
        data_out    <= req_data[pick*DATA_WIDTH +: DATA_WIDTH];
      end
      if (done_set)  done[owner] <= 1'b1;
      if (abort_set) timeout_err <= 1'b1;
      if (grant_set)
        cnt <= '0;
      else if (((state == START) || (state == WAIT_DONE)) && (cnt != CNT_SAT))
        cnt <= cnt + 1'b1;
      if ((state == WAIT_DONE) && (next_state == GAP))
        gap_cnt <= GAP_LOAD;
      else if ((state == GAP) && (gap_cnt != '0))
        gap_cnt <= gap_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single frame, round-robin contention,
// timeout abort, stale completion, early withdraw and mid-frame reset.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant, done;
  logic        tx_start, tx_done, busy, timeout_err;
  logic [7:0]  data_out;
  logic [1:0]  owner;

  int n_pass = 0;
  int n_total = 0;
  int done_cnt = 0;
  int g2_cnt = 0;
  int multi_bad = 0;
  int d0, g0;

  uart_tx_arbiter #(
    .N_REQ(4), .DATA_WIDTH(8), .START_CYCLES(4), .TIMEOUT_CYCLES(100), .GAP_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .grant(grant), .done(done),
    .tx_start(tx_start), .data_out(data_out), .tx_done(tx_done), .busy(busy),
    .owner(owner), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done != 4'b0) done_cnt++;
    if (grant[2]) g2_cnt++;
    if (!$onehot0(grant) || !$onehot0(done)) multi_bad++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_grant(input string tag, input logic [3:0] exp);
    int k;
    step();
    k = 1;
    while (grant === 4'b0 && k < 40) begin
      step();
      k++;
    end
    check(tag, grant, exp);
  endtask

  task automatic wait_done(input string tag, input logic [3:0] exp);
    int k;
    step();
    k = 1;
    while (done === 4'b0 && k < 40) begin
      step();
      k++;
    end
    check(tag, done, exp);
  endtask

  initial begin
    rst = 1'b1; req = 4'b0; req_data = 32'h0; tx_done = 1'b0;
    step(); step();
    check("rst_grant", grant, 4'b0);
    check("rst_done", done, 4'b0);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_data_out", data_out, 8'h00);
    check("rst_owner", owner, 2'd3);
    rst = 1'b0;

    // single request from requester 1
    req = 4'b0010; req_data[15:8] = 8'hA5;
    step();
    check("single_grant", grant, 4'b0010);
    check("single_data", data_out, 8'hA5);
    check("single_tx_start", tx_start, 1'b1);
    check("single_owner", owner, 2'd1);
    req = 4'b0; req_data[15:8] = 8'hFF;
    step();
    check("single_grant_pulse", grant, 4'b0);
    step(); step();
    check("single_tx_start_c4", tx_start, 1'b1);
    step();
    check("single_tx_start_low", tx_start, 1'b0);
    check("single_busy_wait", busy, 1'b1);
    tx_done = 1'b1;
    step(); step();
    check("single_done_early", done, 4'b0);
    step();
    check("single_done", done, 4'b0010);
    step();
    check("single_done_pulse", done, 4'b0);
    check("single_busy_gap", busy, 1'b1);
    step();
    check("single_busy_idle", busy, 1'b0);
    check("single_data_stable", data_out, 8'hA5);
    tx_done = 1'b0;

    // contention: all four requesting, round-robin from 0
    rst = 1'b1; step(); rst = 1'b0;
    req = 4'b1111; req_data = 32'h44332211;
    for (int f = 0; f < 5; f++) begin
      d0 = done_cnt;
      wait_grant("rr_grant", 4'b0001 << (f % 4));
      check("rr_data", data_out, 8'h11 * ((f % 4) + 1));
      repeat (4) step();
      tx_done = 1'b1;
      wait_done("rr_done", 4'b0001 << (f % 4));
      tx_done = 1'b0;
      step();
      check("rr_done_count", done_cnt - d0, 1);
      if (f == 4) req = 4'b0;
    end
    repeat (3) step();

    // timeout on requester 2
    req = 4'b0100; req_data[23:16] = 8'h3C;
    wait_grant("to_grant", 4'b0100);
    req = 4'b0;
    repeat (99) step();
    check("to_done_before", done, 4'b0);
    check("to_err_before", timeout_err, 1'b0);
    check("to_busy_before", busy, 1'b1);
    step();
    check("to_done", done, 4'b0100);
    check("to_err", timeout_err, 1'b1);
    check("to_tx_start", tx_start, 1'b0);
    step();
    check("to_busy_after", busy, 1'b0);
    check("to_done_pulse", done, 4'b0);
    req = 4'b1000; req_data[31:24] = 8'h5A;
    wait_grant("to_next_grant", 4'b1000);
    check("to_next_data", data_out, 8'h5A);
    req = 4'b0;
    repeat (4) step();
    tx_done = 1'b1;
    wait_done("to_next_done", 4'b1000);
    tx_done = 1'b0;
    check("to_err_sticky", timeout_err, 1'b1);
    repeat (3) step();

    // stale completion in START, early withdraw of requester 2
    d0 = done_cnt; g0 = g2_cnt;
    req = 4'b0001;
    wait_grant("stale_grant", 4'b0001);
    req = 4'b0100; tx_done = 1'b1;
    step();
    req = 4'b0;
    repeat (3) step();
    check("stale_in_wait", tx_start, 1'b0);
    check("stale_busy", busy, 1'b1);
    repeat (5) step();
    check("stale_ignored", done_cnt - d0, 0);
    tx_done = 1'b0;
    step(); step();
    tx_done = 1'b1;
    wait_done("stale_real_done", 4'b0001);
    tx_done = 1'b0;
    repeat (6) step();
    check("stale_one_done", done_cnt - d0, 1);
    check("withdraw_no_grant", g2_cnt - g0, 0);

    // reset two cycles into START
    req = 4'b0100;
    wait_grant("rstmid_grant", 4'b0100);
    req = 4'b0;
    step(); step();
    d0 = done_cnt;
    rst = 1'b1;
    step();
    check("rstmid_tx_start", tx_start, 1'b0);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_owner", owner, 2'd3);
    rst = 1'b0;
    repeat (5) step();
    check("rstmid_no_done", done_cnt - d0, 0);
    req = 4'b0001;
    wait_grant("rstmid_regrant", 4'b0001);
    req = 4'b0;
    step();

    check("onehot_grant_done", multi_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
